serial_subtractor_nbits: RTL and testbench

SERIAL_SUBTRACTOR_NBITS -- requirements
Module: serial_subtractor_nbits

---
 rtl/serial_subtractor_nbits.sv | 133 +++++++++++++
 tb/tb_serial_subtractor_nbits.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_nbits.sv
// rtl/serial_subtractor_nbits.sv - bit-serial LSB-first subtractor with borrow, overflow and zero flags
//
// Purpose: computes a - b one bit per clock over width RUN cycles and then
// presents the result with a one-cycle done pulse.
//
// Ports:
//   clk_i    in   clock, rising-edge
//   rst_i    in   synchronous active-high reset
//   start_i  in   request a subtraction (accepted only in IDLE)
//   a_i      in   minuend   [width-1:0]
//   b_i      in   subtrahend [width-1:0]
//   s_o      out  difference a - b mod 2^width (held until next completion)
//   bout_o   out  borrow out (a < b unsigned)
//   ovf_o    out  signed overflow of a - b
//   zero_o   out  difference is all zeros
//   busy_o   out  high in RUN and DONE
//   done_o   out  one-cycle pulse when a new result is presented
module serial_subtractor_nbits #(
    parameter int width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] s_o,
    output logic             bout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int cnt_w = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [width-1:0]   a_sh;
    logic [width-1:0]   b_sh;
    logic [width-1:0]   res_sh;
    logic               a_msb;
    logic               b_msb;
    logic               borrow;
    logic [cnt_w-1:0]   cnt;

    logic               diff_bit;
    logic               borrow_nxt;
    logic               last_bit;
    logic [width-1:0]   res_next;

    // Full-subtractor cell on the current LSB of the operand shift registers.
    assign diff_bit   = a_sh[0] ^ b_sh[0] ^ borrow;
    assign borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    // Bits enter at the MSB end so bit k settles at position k after width shifts.
    assign res_next   = {diff_bit, res_sh[width-1:1]};
    assign last_bit   = (cnt == cnt_w'(width - 1));

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            borrow <= 1'b0;
            cnt    <= '0;
            s_o    <= '0;
            bout_o <= 1'b0;
            ovf_o  <= 1'b0;
            zero_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_sh   <= a_i;
                        b_sh   <= b_i;
                        // Operand sign bits are shifted out during RUN, so keep copies for overflow.
                        a_msb  <= a_i[width-1];
                        b_msb  <= b_i[width-1];
                        res_sh <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    borrow <= borrow_nxt;
                    if (!last_bit) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Visible outputs change only as the last bit completes.
                    if (last_bit) begin
                        s_o    <= res_next;
                        bout_o <= borrow_nxt;
                        ovf_o  <= (a_msb ^ b_msb) & (a_msb ^ res_next[width-1]);
                        zero_o <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_nbits.sv
// tb/tb_serial_subtractor_nbits.sv - directed and random scoreboard bench for serial_subtractor_nbits
module tb_serial_subtractor_nbits;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic [7:0] s_o;
    logic       bout_o;
    logic       ovf_o;
    logic       zero_o;
    logic       busy_o;
    logic       done_o;

    typedef struct {
        logic [7:0] s;
        logic       bout;
        logic       ovf;
        logic       zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    serial_subtractor_nbits #(.width(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .s_o     (s_o),
        .bout_o  (bout_o),
        .ovf_o   (ovf_o),
        .zero_o  (zero_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.s    = a - b;
        e.bout = (a < b);
        e.ovf  = (a[7] != b[7]) && (a[7] != e.s[7]);
        e.zero = (e.s == 8'h00);
        return e;
    endfunction

    task automatic check_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_s"},    32'(s_o),    32'(e.s));
            chk({tag, "_bout"}, 32'(bout_o), 32'(e.bout));
            chk({tag, "_ovf"},  32'(ovf_o),  32'(e.ovf));
            chk({tag, "_zero"}, 32'(zero_o), 32'(e.zero));
        end
    endtask

    // Launch one operation from IDLE, scramble operands after acceptance,
    // and verify latency, the result and the single-cycle done pulse.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input bit full);
        int lat;
        a_i = a;
        b_i = b;
        start_i = 1'b1;
        exp_q.push_back(model(a, b));
        tick();
        start_i = 1'b0;
        a_i = 8'($urandom);
        b_i = 8'($urandom);
        lat = 1;
        while (!done_o && lat < 20) begin
            tick();
            lat++;
        end
        if (full) begin
            chk({tag, "_latency"}, 32'(lat), 32'd9);
        end
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        check_result(tag);
        tick();
        if (full) begin
            chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
            chk({tag, "_idle"}, 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        int dones;
        int t_first;
        int t_second;
        logic [7:0] ra;
        logic [7:0] rb;

        rst_i = 1'b1;
        start_i = 1'b0;
        a_i = 8'h00;
        b_i = 8'h00;
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_s", 32'(s_o), 32'h00);
        chk("rst_flags", {28'd0, bout_o, ovf_o, zero_o, busy_o}, 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);

        run_op("p05_03", 8'h05, 8'h03, 1'b1);
        run_op("p03_05", 8'h03, 8'h05, 1'b1);
        run_op("p80_01", 8'h80, 8'h01, 1'b1);
        run_op("p7f_ff", 8'h7F, 8'hFF, 1'b1);
        run_op("pa5_a5", 8'hA5, 8'hA5, 1'b1);
        run_op("p00_01", 8'h00, 8'h01, 1'b1);

        // start pulsed during RUN must be ignored
        a_i = 8'h10;
        b_i = 8'h01;
        start_i = 1'b1;
        exp_q.push_back(model(8'h10, 8'h01));
        tick();
        start_i = 1'b0;
        tick();
        tick();
        a_i = 8'h00;
        b_i = 8'hFF;
        start_i = 1'b1;
        chk("ign_busy", 32'(busy_o), 32'd1);
        chk("ign_s_held", 32'(s_o), 32'hFF);
        tick();
        start_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            if (done_o) begin
                dones++;
                check_result("ign");
            end
            tick();
        end
        chk("ign_one_done", 32'(dones), 32'd1);
        chk("ign_s_final", 32'(s_o), 32'h0F);

        // continuous start: one result every width+2 cycles
        a_i = 8'h22;
        b_i = 8'h11;
        start_i = 1'b1;
        t_first = -1;
        t_second = -1;
        for (int i = 0; i < 40 && t_second < 0; i++) begin
            tick();
            if (done_o) begin
                if (t_first < 0) t_first = i;
                else t_second = i;
            end
        end
        start_i = 1'b0;
        chk("cont_period", 32'(t_second - t_first), 32'd10);
        chk("cont_s", 32'(s_o), 32'h11);
        for (int i = 0; i < 12 && busy_o; i++) tick();
        chk("cont_drained", 32'(busy_o), 32'd0);

        // reset during the 4th RUN cycle aborts without output
        a_i = 8'h09;
        b_i = 8'h04;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_s", 32'(s_o), 32'h00);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_o) dones++;
            tick();
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        chk("abort_s_kept", 32'(s_o), 32'h00);
        chk("abort_flags", {29'd0, bout_o, ovf_o, zero_o}, 32'd0);

        run_op("post_rst", 8'h05, 8'h03, 1'b1);

        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(0, 7) == 0 ? ra : 8'($urandom));
            run_op("rand", ra, rb, 1'b0);
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
